// File: rtl/icache_if.sv
// icache_if: fetch-side request/response and word-read memory link of the instruction cache.
interface icache_if;
  logic [31:0] pc;
  logic        start_fetch;
  logic        fetch_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  modport slave (
    input  pc, start_fetch, mem_ready, mem_data,
    output fetch_ready, inst, inst_addr, mem_req, mem_addr
  );
  modport master (
    output pc, start_fetch, mem_ready, mem_data,
    input  fetch_ready, inst, inst_addr, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, 4-word lines, refilled one word at a time.
// Define ICACHE_PERF_EN to add hit_cnt/miss_cnt performance counters.
module icache #(
  parameter int INDEX_BITS = 5
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic rob_clear_up,
  icache_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;
  state_t                  state_q;
  logic                    fetch_ready_q, mem_req_q, drop_q;
  logic [31:0]             inst_q, inst_addr_q, mem_addr_q, pc_q;
  logic [1:0]              cnt_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q [LINES];
  logic [3:0][31:0]        data_q [LINES];
  logic [2:0][31:0]        buf_q;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_BITS-1:0]   req_idx, fill_idx;
  logic [3:0][31:0]        fill_line;
  logic                    hit, sample, capture, last;
  assign req_tag   = bus.pc[31:INDEX_BITS+4];
  assign req_idx   = bus.pc[INDEX_BITS+3:4];
  assign fill_idx  = pc_q[INDEX_BITS+3:4];
  assign hit       = valid_q[req_idx] && tag_q[req_idx] == req_tag;
  assign sample    = state_q == IDLE && bus.start_fetch && !rob_clear_up;
  assign capture   = state_q == REFILL && mem_req_q && bus.mem_ready;
  assign last      = capture && cnt_q == 2'd3;
  // Words 0..2 are buffered so a half-filled line never overwrites a valid one.
  assign fill_line = {bus.mem_data, buf_q};
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      fetch_ready_q <= 1'b0;
      inst_q        <= '0;
      inst_addr_q   <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      drop_q        <= 1'b0;
      cnt_q         <= '0;
      pc_q          <= '0;
      valid_q       <= '0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: if (sample) begin
          pc_q <= bus.pc;
          if (hit) begin
            state_q       <= RESP;
            fetch_ready_q <= 1'b1;
            inst_q        <= data_q[req_idx][bus.pc[3:2]];
            inst_addr_q   <= bus.pc;
          end else begin
            state_q    <= REFILL;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {bus.pc[31:4], 4'b0};
            cnt_q      <= '0;
          end
        end
        REFILL: begin
          if (rob_clear_up) drop_q <= 1'b1;
          if (capture) begin
            mem_req_q <= 1'b0;
            cnt_q     <= cnt_q + 2'd1;
          end else if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {pc_q[31:4], cnt_q, 2'b0};
          end
          if (last) begin
            valid_q[fill_idx] <= 1'b1;
            drop_q            <= 1'b0;
            state_q           <= (drop_q || rob_clear_up) ? IDLE : RESP;
            fetch_ready_q     <= !(drop_q || rob_clear_up);
            inst_q            <= fill_line[pc_q[3:2]];
            inst_addr_q       <= pc_q;
          end
        end
        RESP: begin
          state_q       <= IDLE;
          fetch_ready_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && capture) begin
      buf_q <= {bus.mem_data, buf_q[2:1]};
      if (last) begin
        data_q[fill_idx] <= fill_line;
        tag_q[fill_idx]  <= pc_q[31:INDEX_BITS+4];
      end
    end
  end
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_in && sample) begin
      hit_cnt_q  <= hit_cnt_q + {31'd0, hit};
      miss_cnt_q <= miss_cnt_q + {31'd0, !hit};
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
  assign bus.fetch_ready = fetch_ready_q;
  assign bus.inst        = inst_q;
  assign bus.inst_addr   = inst_addr_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache with a small memory responder.
module tb_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  int   req_hi = 0;
  logic [31:0] log_q [$];
  icache_if bus ();
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  icache dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .rob_clear_up(flush),
    .bus(bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (32'hC0DE0000 | a);
  endfunction
  // Memory: answers a request after two cycles and holds mem_ready until mem_req drops.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        req_hi++;
        wait_cnt++;
        if (wait_cnt >= 2 && !bus.mem_ready) begin
          bus.mem_ready = 1'b1;
          bus.mem_data  = memword(bus.mem_addr);
          log_q.push_back(bus.mem_addr);
        end
      end else begin
        wait_cnt = 0;
        bus.mem_ready = 1'b0;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] a, output int lat, output logic seen);
    @(negedge clk);
    bus.pc = a;
    bus.start_fetch = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      seen = bus.fetch_ready;
    end
    @(posedge clk);
    #1;
    bus.start_fetch = 1'b0;
  endtask
  initial begin
    int lat;
    logic seen;
    int r0;
    bus.pc = '0;
    bus.start_fetch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_addr", bus.inst_addr, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
`ifdef ICACHE_PERF_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    // Cold miss at 0x100
    log_q.delete();
    fetch(32'h100, lat, seen);
    check("cold_ready", {31'd0, seen}, 32'd1);
    check("cold_inst", bus.inst, 32'h00500093);
    check("cold_inst_addr", bus.inst_addr, 32'h100);
    check("cold_ready_pulse", {31'd0, bus.fetch_ready}, 32'd0);
    check("cold_words", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      check("cold_addr", log_q[i], 32'h100 + 32'(4 * i));
    // Hit after refill at 0x108
    log_q.delete();
    r0 = req_hi;
    fetch(32'h108, lat, seen);
    check("hit_latency", lat, 1);
    check("hit_inst", bus.inst, 32'hC0DE0108);
    check("hit_inst_addr", bus.inst_addr, 32'h108);
    check("hit_no_mem_req", req_hi - r0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hit_no_resample", {31'd0, bus.mem_req | bus.fetch_ready}, 32'd0);
    // Flush during word 1 of a miss at 0x200
    log_q.delete();
    @(negedge clk);
    bus.pc = 32'h200;
    bus.start_fetch = 1'b1;
    @(negedge clk);
    bus.start_fetch = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (log_q.size() == 1 && bus.mem_req) break;
    end
    check("flush_word1_addr", bus.mem_addr, 32'h204);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen |= bus.fetch_ready;
    end
    check("flush_no_ready", {31'd0, seen}, 32'd0);
    check("flush_words", log_q.size(), 4);
    if (log_q.size() == 4) check("flush_last_addr", log_q[3], 32'h20C);
    log_q.delete();
    fetch(32'h204, lat, seen);
    check("flush_later_hit_lat", lat, 1);
    check("flush_later_hit_inst", bus.inst, 32'hC0DE0204);
    check("flush_later_no_mem", log_q.size(), 0);
    // Stall in RESP
    @(negedge clk);
    bus.pc = 32'h104;
    bus.start_fetch = 1'b1;
    @(posedge clk);
    #1;
    check("stall_ready", {31'd0, bus.fetch_ready}, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_hold", {31'd0, bus.fetch_ready}, 32'd1);
    end
    check("stall_inst", bus.inst, 32'hC0DE0104);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release", {31'd0, bus.fetch_ready}, 32'd0);
    bus.start_fetch = 1'b0;
    // Reset after fill, then conflict sequence
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_inst", bus.inst, 32'd0);
    log_q.delete();
    fetch(32'h100, lat, seen);
    check("rst2_refill_words", log_q.size(), 4);
    check("rst2_inst", bus.inst, 32'h00500093);
    log_q.delete();
    fetch(32'h300, lat, seen);
    check("conf_300_words", log_q.size(), 4);
    if (log_q.size() > 0) check("conf_300_addr", log_q[0], 32'h300);
    check("conf_300_inst", bus.inst, 32'hC0DE0300);
    log_q.delete();
    fetch(32'h100, lat, seen);
    check("conf_100_words", log_q.size(), 4);
    check("conf_100_inst", bus.inst, 32'h00500093);
`ifdef ICACHE_PERF_EN
    check("conf_miss_cnt", miss_cnt, 32'd3);
    check("conf_hit_cnt", hit_cnt, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
